// File: rtl/trap_controller.sv
// trap_controller
//   Machine-mode trap sequencer at the retire boundary. On an illegal-
//   instruction exception, an enabled external interrupt or an MRET, it
//   flushes and stalls the pipeline. It then writes the trap CSRs through the
//   single CSR write port, one CSR per cycle, and finally issues one fetch
//   redirect.
//
//   Build option: define TRAP_MTVAL_EN to add the MTVAL write step. MTVAL gets
//   the faulting instruction for illegal instructions and 0 for interrupts.
//
// Ports
//   clock, reset          core clock, synchronous active-high reset
//   retireValid/Illegal/Mret/PC/NextPC/Instruction
//                         retiring instruction, sampled only while idle
//   interrupt             level-sensitive machine external interrupt
//   mstatusValue, mieValue, mtvecValue, mepcValue
//                         current CSR contents
//   csrWriteEnable/Select/Data
//                         CSR write port (0=MSTATUS 1=MEPC 2=MCAUSE 3=MTVAL)
//   pipelineFlush, fetchStall
//                         asserted for the whole trap/return sequence
//   redirectValid, redirectPC
//                         one-cycle fetch redirect at the end of the sequence
//   trapBusy              sequencer is not idle
module trap_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        retireValid,
   input  logic        retireIllegal,
   input  logic        retireMret,
   input  logic [31:0] retirePC,
   input  logic [31:0] retireNextPC,
   input  logic [31:0] retireInstruction,
   input  logic        interrupt,
   input  logic [31:0] mstatusValue,
   input  logic [31:0] mieValue,
   input  logic [31:0] mtvecValue,
   input  logic [31:0] mepcValue,
   output logic        csrWriteEnable,
   output logic [1:0]  csrWriteSelect,
   output logic [31:0] csrWriteData,
   output logic        pipelineFlush,
   output logic        fetchStall,
   output logic        redirectValid,
   output logic [31:0] redirectPC,
   output logic        trapBusy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      T_MEPC    = 3'd1,
      T_MCAUSE  = 3'd2,
`ifdef TRAP_MTVAL_EN
      T_MTVAL   = 3'd3,
`endif
      T_MSTATUS = 3'd4,
      R_MSTATUS = 3'd5,
      REDIRECT  = 3'd6
   } state_t;

   localparam logic [1:0]  SEL_MSTATUS = 2'd0;
   localparam logic [1:0]  SEL_MEPC    = 2'd1;
   localparam logic [1:0]  SEL_MCAUSE  = 2'd2;
`ifdef TRAP_MTVAL_EN
   localparam logic [1:0]  SEL_MTVAL   = 2'd3;
`endif
   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

   // MPIE <- MIE, MIE <- 0, MPP <- M
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
      logic [31:0] r;
      r        = ms;
      r[7]     = ms[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // MIE <- MPIE, MPIE <- 1, MPP stays M (machine-only core)
   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
      logic [31:0] r;
      r        = ms;
      r[3]     = ms[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [31:2] epc_q, epc_d;   // MEPC is always written word-aligned
   logic        irq_q, irq_d;   // selects MCAUSE value
   logic        mret_q, mret_d; // selects redirect source
`ifdef TRAP_MTVAL_EN
   logic [31:0] tval_q, tval_d;
`endif

   logic take_exc, take_mret, take_irq;

   assign take_exc  = retireValid && retireIllegal;
   assign take_mret = retireValid && retireMret && !retireIllegal;
   // An interrupt is only taken alongside a retiring instruction so that
   // MEPC always has a well-defined resume point.
   assign take_irq  = retireValid && !retireIllegal && !retireMret &&
                      interrupt && mstatusValue[3] && mieValue[11];

   logic unused_bits;
`ifdef TRAP_MTVAL_EN
   assign unused_bits = ^{mieValue[31:12], mieValue[10:0], mtvecValue[1:0],
                          mepcValue[1:0], retirePC[1:0], retireNextPC[1:0]};
`else
   assign unused_bits = ^{mieValue[31:12], mieValue[10:0], mtvecValue[1:0],
                          mepcValue[1:0], retirePC[1:0], retireNextPC[1:0],
                          retireInstruction};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         epc_q   <= '0;
         irq_q   <= 1'b0;
         mret_q  <= 1'b0;
`ifdef TRAP_MTVAL_EN
         tval_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         irq_q   <= irq_d;
         mret_q  <= mret_d;
`ifdef TRAP_MTVAL_EN
         tval_q  <= tval_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      irq_d   = irq_q;
      mret_d  = mret_q;
`ifdef TRAP_MTVAL_EN
      tval_d  = tval_q;
`endif
      case (state_q)
         IDLE: begin
            if (take_exc) begin
               state_d = T_MEPC;
               epc_d   = retirePC[31:2];
               irq_d   = 1'b0;
               mret_d  = 1'b0;
`ifdef TRAP_MTVAL_EN
               tval_d  = retireInstruction;
`endif
            end else if (take_mret) begin
               state_d = R_MSTATUS;
               mret_d  = 1'b1;
            end else if (take_irq) begin
               state_d = T_MEPC;
               epc_d   = retireNextPC[31:2];
               irq_d   = 1'b1;
               mret_d  = 1'b0;
`ifdef TRAP_MTVAL_EN
               tval_d  = '0;
`endif
            end
         end
         T_MEPC:    state_d = T_MCAUSE;
`ifdef TRAP_MTVAL_EN
         T_MCAUSE:  state_d = T_MTVAL;
         T_MTVAL:   state_d = T_MSTATUS;
`else
         T_MCAUSE:  state_d = T_MSTATUS;
`endif
         T_MSTATUS: state_d = REDIRECT;
         R_MSTATUS: state_d = REDIRECT;
         REDIRECT:  state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      csrWriteEnable = 1'b0;
      csrWriteSelect = 2'd0;
      csrWriteData   = '0;
      redirectValid  = 1'b0;
      redirectPC     = RESET_VECTOR;
      case (state_q)
         T_MEPC: begin
            csrWriteEnable = 1'b1;
            csrWriteSelect = SEL_MEPC;
            csrWriteData   = {epc_q, 2'b00};
         end
         T_MCAUSE: begin
            csrWriteEnable = 1'b1;
            csrWriteSelect = SEL_MCAUSE;
            csrWriteData   = irq_q ? CAUSE_MEI : CAUSE_ILLEGAL;
         end
`ifdef TRAP_MTVAL_EN
         T_MTVAL: begin
            csrWriteEnable = 1'b1;
            csrWriteSelect = SEL_MTVAL;
            csrWriteData   = tval_q;
         end
`endif
         T_MSTATUS: begin
            csrWriteEnable = 1'b1;
            csrWriteSelect = SEL_MSTATUS;
            csrWriteData   = mstatus_on_trap(mstatusValue);
         end
         R_MSTATUS: begin
            csrWriteEnable = 1'b1;
            csrWriteSelect = SEL_MSTATUS;
            csrWriteData   = mstatus_on_mret(mstatusValue);
         end
         REDIRECT: begin
            // CSR writes have settled by now, so mtvec/mepc are current.
            redirectValid = 1'b1;
            redirectPC    = mret_q ? {mepcValue[31:2], 2'b00}
                                   : {mtvecValue[31:2], 2'b00};
         end
         default: ;
      endcase
   end

   assign pipelineFlush = (state_q != IDLE);
   assign fetchStall    = (state_q != IDLE);
   assign trapBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller
//   Bench for trap_controller. Drives directed and random retire events,
//   predicts the CSR write stream and redirect for each one, and checks the
//   outputs cycle by cycle. Honours TRAP_MTVAL_EN in the same way as the design.
module tb_trap_controller;

   localparam logic [31:0] RV = 32'h0000_1000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        retireValid = 1'b0;
   logic        retireIllegal = 1'b0;
   logic        retireMret = 1'b0;
   logic [31:0] retirePC = '0;
   logic [31:0] retireNextPC = '0;
   logic [31:0] retireInstruction = '0;
   logic        interrupt = 1'b0;
   logic [31:0] mstatusValue = '0;
   logic [31:0] mieValue = '0;
   logic [31:0] mtvecValue = '0;
   logic [31:0] mepcValue = '0;
   logic        csrWriteEnable;
   logic [1:0]  csrWriteSelect;
   logic [31:0] csrWriteData;
   logic        pipelineFlush;
   logic        fetchStall;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        trapBusy;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   trap_controller #(.RESET_VECTOR(RV)) dut (
      .clock(clock), .reset(reset),
      .retireValid(retireValid), .retireIllegal(retireIllegal),
      .retireMret(retireMret), .retirePC(retirePC),
      .retireNextPC(retireNextPC), .retireInstruction(retireInstruction),
      .interrupt(interrupt),
      .mstatusValue(mstatusValue), .mieValue(mieValue),
      .mtvecValue(mtvecValue), .mepcValue(mepcValue),
      .csrWriteEnable(csrWriteEnable), .csrWriteSelect(csrWriteSelect),
      .csrWriteData(csrWriteData), .pipelineFlush(pipelineFlush),
      .fetchStall(fetchStall), .redirectValid(redirectValid),
      .redirectPC(redirectPC), .trapBusy(trapBusy)
   );

   // One expected non-idle cycle.
   typedef struct {
      logic        we;
      logic [1:0]  sel;
      logic [31:0] data;
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".we"},    csrWriteEnable, 0);
      chk({tag, ".sel"},   csrWriteSelect, 0);
      chk({tag, ".data"},  csrWriteData,   0);
      chk({tag, ".rv"},    redirectValid,  0);
      chk({tag, ".rpc"},   redirectPC,     RV);
      chk({tag, ".flush"}, pipelineFlush,  0);
      chk({tag, ".stall"}, fetchStall,     0);
      chk({tag, ".busy"},  trapBusy,       0);
   endtask

   task automatic clear_retire();
      retireValid   = 1'b0;
      retireIllegal = 1'b0;
      retireMret    = 1'b0;
      interrupt     = 1'b0;
   endtask

   // Presents one event in an idle cycle, then follows the whole sequence,
   // throwing random retire traffic at the design while it is busy, and ends
   // on the idle cycle that follows.
   task automatic do_event(input string tag, input logic v, input logic ill,
                           input logic mr, input logic irq,
                           input logic [31:0] pc, input logic [31:0] npc,
                           input logic [31:0] ins, input logic [31:0] ms,
                           input logic [31:0] mie, input logic [31:0] tvec,
                           input logic [31:0] mepc);
      exp_t        q[$];
      logic        is_exc, is_ret, is_irq;
      logic [31:0] epc, cause, tval, tgt;
      retireValid = v; retireIllegal = ill; retireMret = mr; interrupt = irq;
      retirePC = pc; retireNextPC = npc; retireInstruction = ins;
      mstatusValue = ms; mieValue = mie; mtvecValue = tvec; mepcValue = mepc;

      is_exc = v && ill;
      is_ret = v && mr && !ill;
      is_irq = v && !ill && !mr && irq && ms[3] && mie[11];
      if (is_exc || is_irq) begin
         epc   = is_exc ? pc : npc;
         cause = is_exc ? 32'd2 : 32'h8000_000B;
         tval  = is_exc ? ins : 32'd0;
         tgt   = tvec & ~32'h3;
         q.push_back('{we: 1, sel: 2'd1, data: epc & ~32'h3, rv: 0, rpc: 0});
         q.push_back('{we: 1, sel: 2'd2, data: cause, rv: 0, rpc: 0});
`ifdef TRAP_MTVAL_EN
         q.push_back('{we: 1, sel: 2'd3, data: tval, rv: 0, rpc: 0});
`endif
         q.push_back('{we: 1, sel: 2'd0,
                       data: (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800,
                       rv: 0, rpc: 0});
         q.push_back('{we: 0, sel: 2'd0, data: 0, rv: 1, rpc: tgt});
      end else if (is_ret) begin
         tgt = mepc & ~32'h3;
         q.push_back('{we: 1, sel: 2'd0,
                       data: (ms & ~32'h88) | (ms[7] ? 32'h8 : 32'h0) | 32'h1880,
                       rv: 0, rpc: 0});
         q.push_back('{we: 0, sel: 2'd0, data: 0, rv: 1, rpc: tgt});
      end
      step();
      foreach (q[i]) begin
         string t;
         t = $sformatf("%s.c%0d", tag, i + 1);
         chk({t, ".we"},    csrWriteEnable, q[i].we);
         chk({t, ".sel"},   csrWriteSelect, q[i].sel);
         chk({t, ".data"},  csrWriteData,   q[i].data);
         chk({t, ".rv"},    redirectValid,  q[i].rv);
         if (q[i].rv) chk({t, ".rpc"}, redirectPC, q[i].rpc);
         chk({t, ".flush"}, pipelineFlush,  1);
         chk({t, ".stall"}, fetchStall,     1);
         chk({t, ".busy"},  trapBusy,       1);
         retireValid       = 1'b1;
         retireIllegal     = ($urandom_range(0, 1) == 1);
         retireMret        = ($urandom_range(0, 1) == 1);
         interrupt         = 1'b1;
         retirePC          = $urandom;
         retireNextPC      = $urandom;
         retireInstruction = $urandom;
         step();
      end
      clear_retire();
      check_idle({tag, ".end"});
   endtask

   initial begin
      logic        v, ill, mr, irq;
      logic [31:0] ms, mie, pc, npc, ins, tvec, mepc;

      // reset, including an event presented while reset is held
      step();
      check_idle("reset0");
      retireValid = 1'b1; retireIllegal = 1'b1; retirePC = 32'h100;
      step();
      check_idle("reset1");
      clear_retire();
      reset = 1'b0;
      step();
      check_idle("idle0");

      do_event("illegal", 1, 1, 0, 0, 32'h100, 32'h104, 32'hDEAD_BEEF,
               32'h8, 32'h0, 32'h200, 32'h0);
      do_event("irq_on", 1, 0, 0, 1, 32'h40, 32'h80, 32'h0,
               32'h8, 32'h800, 32'h200, 32'h0);
      do_event("irq_mie0", 1, 0, 0, 1, 32'h40, 32'h80, 32'h0,
               32'h8, 32'h0, 32'h200, 32'h0);
      do_event("irq_mstatus0", 1, 0, 0, 1, 32'h40, 32'h80, 32'h0,
               32'h0, 32'h800, 32'h200, 32'h0);
      do_event("irq_noretire", 0, 0, 0, 1, 32'h40, 32'h80, 32'h0,
               32'h8, 32'h800, 32'h200, 32'h0);
      do_event("mret", 1, 0, 1, 0, 32'h300, 32'h304, 32'h0,
               32'h1880, 32'h0, 32'h200, 32'h104);
      do_event("all3", 1, 1, 1, 1, 32'h204, 32'h208, 32'h1234_5677,
               32'h8, 32'h800, 32'h400, 32'h104);
      // back-to-back: interrupt accepted in the idle cycle right after a trap
      do_event("b2b_a", 1, 1, 0, 0, 32'h0FC, 32'h100, 32'h0000_0013,
               32'h88, 32'h800, 32'h203, 32'h0);
      do_event("b2b_b", 1, 0, 0, 1, 32'h500, 32'h502, 32'h0,
               32'h88, 32'h800, 32'h203, 32'h0);

      // reset while MCAUSE is being written
      retireValid = 1'b1; retireIllegal = 1'b1; retirePC = 32'h100;
      mstatusValue = 32'h8; mtvecValue = 32'h200;
      step();
      chk("rst_mid.mepc_we",  csrWriteEnable, 1);
      chk("rst_mid.mepc_sel", csrWriteSelect, 1);
      clear_retire();
      step();
      chk("rst_mid.mcause_sel",  csrWriteSelect, 2);
      chk("rst_mid.mcause_data", csrWriteData,   2);
      reset = 1'b1;
      step();
      check_idle("rst_mid.r");
      reset = 1'b0;
      step();
      check_idle("rst_mid.a1");
      step();
      check_idle("rst_mid.a2");

      for (int i = 0; i < 60; i++) begin
         v    = ($urandom_range(0, 9) != 0);
         ill  = ($urandom_range(0, 3) == 0);
         mr   = ($urandom_range(0, 3) == 0);
         irq  = ($urandom_range(0, 1) == 1);
         ms   = $urandom;
         mie  = $urandom;
         pc   = $urandom;
         npc  = $urandom;
         ins  = $urandom;
         tvec = $urandom;
         mepc = $urandom;
         do_event($sformatf("rnd%0d", i), v, ill, mr, irq, pc, npc, ins,
                  ms, mie, tvec, mepc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap sequencer at the retire boundary of the five-stage core. It takes illegal-instruction exceptions, gated external interrupts and MRET. For each event it flushes the pipeline, writes MEPC/MCAUSE/(MTVAL)/MSTATUS through the CSR file's single write port, one CSR per cycle, then issues one fetch redirect. It sits beside writeback and feeds the hazard unit's global flush/stall and the fetch redirect mux.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, redirectPC value held while idle/reset (don't-care when redirectValid=0)

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- retireValid  in  1  an instruction reaches retire this cycle
- retireIllegal  in  1  retiring instruction carries illegal flag
- retireMret  in  1  retiring instruction is MRET
- retirePC  in  32  PC of retiring instruction
- retireNextPC  in  32  architectural next PC of retiring instruction (PC+4 or taken target)
- retireInstruction  in  32  raw encoding of retiring instruction (used only with TRAP_MTVAL_EN)
- interrupt  in  1  level-sensitive machine external interrupt
- mstatusValue, mieValue, mtvecValue, mepcValue  in  32 each  current CSR contents
- csrWriteEnable  out  1  CSR write strobe
- csrWriteSelect  out  2  0=MSTATUS, 1=MEPC, 2=MCAUSE, 3=MTVAL
- csrWriteData  out  32  CSR write value
- pipelineFlush  out  1  invalidate all stage payloads
- fetchStall  out  1  hold fetch PC
- redirectValid  out  1  one-cycle fetch redirect
- redirectPC  out  32  redirect target
- trapBusy  out  1  state != IDLE

## Operation
- States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL (macro only), T_MSTATUS, R_MSTATUS, REDIRECT.
- IDLE event decode, priority high→low:
  1. Exception: retireValid && retireIllegal. Latch epc=retirePC, cause=32'd2, tval=retireInstruction.
  2. MRET: retireValid && retireMret && !retireIllegal. Go to R_MSTATUS.
  3. Interrupt: retireValid && !retireIllegal && !retireMret && interrupt && mstatusValue[3] && mieValue[11]. Latch epc=retireNextPC, cause=32'h8000_000B, tval=0.
- Exceptions and interrupts go to T_MEPC.
- Interrupt with no retiring instruction is not taken; it is re-evaluated each cycle.
- T_MEPC: write MEPC = {epc[31:2],2'b00}. Go to T_MCAUSE.
- T_MCAUSE: write MCAUSE = cause. Go to T_MTVAL if macro defined, else T_MSTATUS.
- T_MTVAL: write MTVAL = tval. Go to T_MSTATUS.
- T_MSTATUS: write mstatusValue with bit7(MPIE) = mstatusValue[3], bit3(MIE) = 0, [12:11] = 2'b11. Go to REDIRECT.
- R_MSTATUS: write mstatusValue with bit3 = mstatusValue[7], bit7 = 1, [12:11] = 2'b11. Go to REDIRECT.
- REDIRECT: redirectValid=1.
  - After a trap: redirectPC = {mtvecValue[31:2],2'b00} (direct mode only).
  - After MRET: redirectPC = {mepcValue[31:2],2'b00}.
  - Go to IDLE.
- pipelineFlush=1 and fetchStall=1 in every non-IDLE state.
- All retire/interrupt inputs are ignored outside IDLE.
- csrWriteEnable=1 only in T_* and R_MSTATUS states; csrWriteSelect/csrWriteData are 0 elsewhere.

## Timing
- Reset (any state, mid-sequence included): state→IDLE, latches cleared. All outputs 0 except redirectPC=RESET_VECTOR. A partially written trap is abandoned.
- Event sampled at edge N (IDLE).
- Trap, macro off: MEPC write cycle N+1, MCAUSE N+2, MSTATUS N+3, REDIRECT N+4. IDLE at N+5.
- Trap, macro on: each step after MCAUSE shifts +1; REDIRECT at N+5.
- MRET: MSTATUS write N+1, REDIRECT N+2.
- Each CSR write commits at the closing edge of its cycle. CSR reads in the following cycle see the new value, so REDIRECT reads the settled mtvec/mepc.
- Outputs decode from registered state and latches plus current CSR inputs; there is no combinational path from retire inputs to outputs.
- Back-to-back events: the first cycle after REDIRECT is IDLE and may accept a new event. An interrupt pending at that point is blocked only if MIE=0.

## Configuration
- TRAP_MTVAL_EN defined: T_MTVAL state exists. MTVAL = faulting instruction for illegal, 0 for interrupts. Trap latency is 5 cycles.
- TRAP_MTVAL_EN undefined: T_MTVAL is removed, select 3 is never driven and retireInstruction is unused. Trap latency is 4 cycles.

## Test plan
- Illegal at retirePC=0x100, mstatus=0x8, mtvec=0x200 → MEPC=0x100, MCAUSE=2, MSTATUS=0x1880, redirectPC=0x200 at N+4 (N+5 and MTVAL written with macro).
- interrupt=1, mstatus=0x8, mie=0x800, retire at PC=0x40 with retireNextPC=0x80 → MEPC=0x80, MCAUSE=0x8000000B; with mie=0 no trap.
- MRET with mstatus=0x1880, mepc=0x104 → MSTATUS=0x1888 at N+1, redirect 0x104 at N+2.
- Illegal, MRET and interrupt in the same cycle → exception path only, MCAUSE=2.
- Reset asserted in T_MCAUSE → next cycle IDLE, all outputs 0, no further CSR writes.
- Retire events during a busy sequence → ignored; exactly one redirect per event.
